// File: rtl/spi_tx_feeder.sv
// Word FIFO plus request FSM that feeds SPI_master one word per frame.
// Counts completed frames and flags dropped pushes and request timeouts.
module spi_tx_feeder #(
    parameter int DATA_W  = 12,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255,
    parameter int GAP     = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       new_data,
    output logic [DATA_W-1:0]          din,
    input  logic                       cs,
    output logic                       busy,
    output logic [15:0]                tx_count,
    output logic                       overflow,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUSY,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   din_q, din_d;
    logic                new_data_q, new_data_d;
    logic [WW-1:0]       wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [15:0]         tx_count_q, tx_count_d;
    logic                overflow_q, overflow_d;
    logic                timeout_err_q, timeout_err_d;
    logic                cs_m_q, cs_s_q;
    logic [AW:0]         level_w;
    logic                push;

    // Extra pointer MSB distinguishes full from empty
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full    = (level_w == (AW + 1)'(DEPTH));
    assign empty   = (level_w == '0);
    assign push    = wr_en && !full;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        din_d         = din_q;
        new_data_d    = new_data_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        tx_count_d    = tx_count_q;
        overflow_d    = overflow_q | (wr_en & full);
        timeout_err_d = timeout_err_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    din_d      = mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_d   = rd_ptr_q + (AW + 1)'(1);
                    new_data_d = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (!cs_s_q) begin
                    new_data_d = 1'b0;
                    state_d    = S_BUSY;
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    // Word already popped; abandoning it drops it
                    new_data_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_BUSY: begin
                if (cs_s_q) begin
                    tx_count_d = tx_count_q + 16'd1;
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            din_q         <= '0;
            new_data_q    <= 1'b0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            tx_count_q    <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            cs_m_q        <= 1'b1;
            cs_s_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            din_q         <= din_d;
            new_data_q    <= new_data_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            tx_count_q    <= tx_count_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
            cs_m_q        <= cs;
            cs_s_q        <= cs_m_q;
        end
    end

    assign level       = level_w;
    assign new_data    = new_data_q;
    assign din         = din_q;
    assign busy        = (state_q != S_IDLE);
    assign tx_count    = tx_count_q;
    assign overflow    = overflow_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench for spi_tx_feeder: handshake, FIFO fill/overflow,
// request timeout, simultaneous push/pop and mid-frame reset.
module tb_spi_tx_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        new_data;
    logic [11:0] din;
    logic        cs;
    logic        busy;
    logic [15:0] tx_count;
    logic        overflow;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;
    int hi;

    spi_tx_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .new_data    (new_data),
        .din         (din),
        .cs          (cs),
        .busy        (busy),
        .tx_count    (tx_count),
        .overflow    (overflow),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_level"}, 32'(level), 0);
        check({tag, "_new_data"}, 32'(new_data), 0);
        check({tag, "_din"}, 32'(din), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_tx_count"}, 32'(tx_count), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, 32'(busy), 0);
    endtask

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        cs      = 1'b1;
        tick();
        tick();
        check_reset_vals("rst0");
        rst = 1'b1;

        // Single word, full handshake
        wr_en   = 1'b1;
        wr_data = 12'hA5C;
        tick();
        wr_en = 1'b0;
        check("push_level", 32'(level), 1);
        check("push_empty", 32'(empty), 0);
        check("push_nd_low", 32'(new_data), 0);
        tick();
        check("req_nd", 32'(new_data), 1);
        check("req_din", 32'(din), 32'h0A5C);
        check("req_busy", 32'(busy), 1);
        check("req_level", 32'(level), 0);
        repeat (30) tick();
        cs  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt++;
            if (!new_data) break;
        end
        check("nd_drop_lat", 32'(cnt >= 2 && cnt <= 3), 1);
        check("nd_dropped", 32'(new_data), 0);
        repeat (297) tick();
        check("frame_busy", 32'(busy), 1);
        check("frame_cnt0", 32'(tx_count), 0);
        check("frame_no_to", 32'(timeout_err), 0);
        cs = 1'b1;
        repeat (2) tick();
        check("cs_sync_cnt", 32'(tx_count), 0);
        tick();
        check("tx_count1", 32'(tx_count), 1);
        check("gap_busy", 32'(busy), 1);
        repeat (23) tick();
        check("gap_hold", 32'(busy), 1);
        tick();
        check("gap_end", 32'(busy), 0);

        // Fill with cs held high: overflow then timeout
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 12'h100 + 12'(i);
            tick();
            if (new_data) hi++;
            if (i == 8) begin
                check("fill9_level", 32'(level), 8);
                check("fill9_full", 32'(full), 1);
                check("fill9_ovf", 32'(overflow), 0);
            end
        end
        wr_en = 1'b0;
        check("fill10_level", 32'(level), 8);
        check("fill10_ovf", 32'(overflow), 1);
        check("fill_din", 32'(din), 32'h100);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (new_data) hi++;
            else break;
        end
        check("to_nd_cycles", 32'(hi), 255);
        check("to_err", 32'(timeout_err), 1);
        check("to_level", 32'(level), 8);
        wr_en   = 1'b1;
        wr_data = 12'hBAD;
        tick();
        wr_en = 1'b0;
        check("to_next_nd", 32'(new_data), 1);
        check("to_next_din", 32'(din), 32'h101);
        check("full_push_pop", 32'(level), 7);

        // Level bookkeeping with simultaneous push/pop
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 12'h201 + 12'(i);
            tick();
        end
        wr_en = 1'b0;
        check("lv_req_level", 32'(level), 3);
        check("lv_req_din", 32'(din), 32'h201);
        cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!new_data) break;
        end
        check("lv_accept", 32'(new_data), 0);
        cs = 1'b1;
        wait_idle("lv_idle");
        check("lv_idle_level", 32'(level), 3);
        check("lv_tx_count", 32'(tx_count), 1);
        wr_en   = 1'b1;
        wr_data = 12'h205;
        tick();
        check("pop_push_level", 32'(level), 3);
        check("pop_push_din", 32'(din), 32'h202);
        wr_data = 12'h206;
        tick();
        check("req_push_level", 32'(level), 4);
        wr_data = 12'h207;
        tick();
        wr_en = 1'b0;
        check("level5", 32'(level), 5);

        // Reset in the middle of a frame
        cs = 1'b0;
        repeat (3) tick();
        check("mid_busy", 32'(busy), 1);
        check("mid_nd", 32'(new_data), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_vals("rst_mid");
        cs = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
